// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns the SPI client's byte stream into wavegen control registers.
// Define CMD_CHECKSUM_EN to require a trailing XOR checksum byte on multi-byte commands.
//
// state | meaning
// IDLE  | waiting for an opcode byte
// DATA  | collecting data bytes of SET_FREQ / SET_AMP
// CHECK | waiting for the checksum byte (CMD_CHECKSUM_EN only)
module spi_cmd_decoder #(
  parameter int                      FREQ_BYTES     = 2,
  parameter logic [8*FREQ_BYTES-1:0] FREQ_DEFAULT   = 'h0100,
  parameter logic [7:0]              AMP_DEFAULT    = 8'hFF,
  parameter int                      TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                command,
  input  logic                      command_signal,
  output logic [1:0]                wave_sel,
  output logic [8*FREQ_BYTES-1:0]   freq_word,
  output logic [7:0]                amplitude,
  output logic                      out_en,
  output logic                      update,
  output logic                      cmd_error,
  output logic                      busy
);

  localparam int W  = 8 * FREQ_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(FREQ_BYTES + 1);

`ifdef CMD_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, DATA, CHECK} state_t;
  logic [7:0]   csum;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
`endif

  state_t        state;
  logic [TW-1:0] timer;
  logic [CW-1:0] byte_cnt;
  logic [W-1:0]  stage;
  logic          op_freq;

  logic [W-1:0]  stage_shl;
  logic          last_byte;
  logic          timer_done;

  assign stage_shl  = (stage << 8) | W'(command);
  assign last_byte  = op_freq ? (byte_cnt == CW'(FREQ_BYTES - 1)) : (byte_cnt == '0);
  assign timer_done = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      byte_cnt  <= '0;
      stage     <= '0;
      op_freq   <= 1'b0;
      wave_sel  <= 2'd0;
      freq_word <= FREQ_DEFAULT;
      amplitude <= AMP_DEFAULT;
      out_en    <= 1'b0;
      update    <= 1'b0;
      cmd_error <= 1'b0;
      busy      <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      update    <= 1'b0;
      cmd_error <= 1'b0;
      case (state)
        IDLE: begin
          if (command_signal) begin
            case (command[7:4])
              4'h1: begin
                wave_sel <= command[1:0];
                update   <= 1'b1;
              end
              4'h2, 4'h3: begin
                op_freq  <= (command[7:4] == 4'h2);
                byte_cnt <= '0;
                timer    <= '0;
                stage    <= '0;
                busy     <= 1'b1;
                state    <= DATA;
`ifdef CMD_CHECKSUM_EN
                csum     <= command;
`endif
              end
              4'h4: begin
                out_en <= command[0];
                update <= 1'b1;
              end
              default: cmd_error <= 1'b1;
            endcase
          end
        end

        DATA: begin
          if (command_signal) begin
            // A strobe coincident with timer expiry still counts as a valid byte.
            timer    <= '0;
            stage    <= stage_shl;
            byte_cnt <= byte_cnt + 1'b1;
`ifdef CMD_CHECKSUM_EN
            csum     <= csum ^ command;
            if (last_byte) state <= CHECK;
`else
            if (last_byte) begin
              if (op_freq) freq_word <= stage_shl;
              else         amplitude <= command;
              update <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
`endif
          end else if (timer_done) begin
            cmd_error <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

`ifdef CMD_CHECKSUM_EN
        CHECK: begin
          if (command_signal) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= IDLE;
            if (command == csum) begin
              if (op_freq) freq_word <= stage;
              else         amplitude <= stage[7:0];
              update <= 1'b1;
            end else begin
              cmd_error <= 1'b1;
            end
          end else if (timer_done) begin
            cmd_error <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
`endif

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder; works with or without CMD_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_spi_cmd_decoder;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  command;
  logic        command_signal;
  logic [1:0]  wave_sel;
  logic [15:0] freq_word;
  logic [7:0]  amplitude;
  logic        out_en, update, cmd_error, busy;

  int n_cmp = 0;
  int n_bad = 0;

  spi_cmd_decoder #(
    .FREQ_BYTES(2), .FREQ_DEFAULT(16'h0100), .AMP_DEFAULT(8'hFF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .command(command), .command_signal(command_signal),
    .wave_sel(wave_sel), .freq_word(freq_word), .amplitude(amplitude),
    .out_en(out_en), .update(update), .cmd_error(cmd_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe one byte; returns 1ns after the edge that samples it.
  task automatic strobe(input logic [7:0] b);
    @(negedge clk);
    command        = b;
    command_signal = 1'b1;
    @(posedge clk);
    #1;
    command_signal = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the checksum byte only when the option is built in.
  task automatic finish_cmd(input logic [7:0] c);
`ifdef CMD_CHECKSUM_EN
    strobe(c);
`else
    c = c;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(4);
    n_cmp++; if (wave_sel !== 2'd0)      begin n_bad++; $display("FAIL reset_wave got %0h want 0", wave_sel); end
    n_cmp++; if (freq_word !== 16'h0100) begin n_bad++; $display("FAIL reset_freq got %0h want 0100", freq_word); end
    n_cmp++; if (amplitude !== 8'hFF)    begin n_bad++; $display("FAIL reset_amp got %0h want ff", amplitude); end
    n_cmp++; if (out_en !== 1'b0)        begin n_bad++; $display("FAIL reset_en got %b want 0", out_en); end
    n_cmp++; if (busy !== 1'b0)          begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if ({update, cmd_error} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses got %b want 00", {update, cmd_error}); end
  endtask

  task automatic test_single;
    strobe(8'h12);
    n_cmp++; if (wave_sel !== 2'd2) begin n_bad++; $display("FAIL set_wave got %0d want 2", wave_sel); end
    n_cmp++; if (update !== 1'b1)   begin n_bad++; $display("FAIL set_wave_upd got %b want 1", update); end
    idle(1);
    n_cmp++; if (update !== 1'b0)   begin n_bad++; $display("FAIL upd_one_cycle got %b want 0", update); end
    strobe(8'h41);
    n_cmp++; if (out_en !== 1'b1)   begin n_bad++; $display("FAIL set_en got %b want 1", out_en); end
    n_cmp++; if ({update, cmd_error} !== 2'b10) begin n_bad++; $display("FAIL set_en_pulse got %b want 10", {update, cmd_error}); end
  endtask

  task automatic test_freq;
    strobe(8'h20);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL freq_busy got %b want 1", busy); end
    idle(9);
    strobe(8'h12);
    n_cmp++; if (freq_word !== 16'h0100) begin n_bad++; $display("FAIL freq_partial got %h want 0100", freq_word); end
    idle(9);
    strobe(8'h34);
`ifdef CMD_CHECKSUM_EN
    n_cmp++; if (freq_word !== 16'h0100) begin n_bad++; $display("FAIL freq_pre_csum got %h want 0100", freq_word); end
`endif
    finish_cmd(8'h06);
    n_cmp++; if (freq_word !== 16'h1234) begin n_bad++; $display("FAIL freq_word got %h want 1234", freq_word); end
    n_cmp++; if ({update, busy} !== 2'b10) begin n_bad++; $display("FAIL freq_done got upd/busy %b want 10", {update, busy}); end
  endtask

  task automatic test_timeout;
    int early;
    early = 0;
    strobe(8'h20);
    strobe(8'hAB);
    for (int i = 0; i < TO - 1; i++) begin
      @(posedge clk);
      #1;
      if (cmd_error !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL timeout_early got %0d bad cycles want 0", early); end
    idle(1);
    n_cmp++; if ({cmd_error, update, busy} !== 3'b100) begin n_bad++; $display("FAIL timeout_pulse got err/upd/busy %b want 100", {cmd_error, update, busy}); end
    n_cmp++; if (freq_word !== 16'h1234) begin n_bad++; $display("FAIL timeout_freq got %h want 1234", freq_word); end
    idle(1);
    n_cmp++; if (cmd_error !== 1'b0) begin n_bad++; $display("FAIL timeout_single got %b want 0", cmd_error); end
    strobe(8'h31);
    strobe(8'h80);
    finish_cmd(8'hB1);
    n_cmp++; if (amplitude !== 8'h80) begin n_bad++; $display("FAIL amp_after_to got %h want 80", amplitude); end
    // Data byte arriving exactly at the expiry cycle must be accepted.
    strobe(8'h31);
    idle(TO - 1);
    strobe(8'h22);
    finish_cmd(8'h13);
    n_cmp++; if ({amplitude, update, cmd_error} !== {8'h22, 2'b10}) begin n_bad++; $display("FAIL strobe_at_expiry got amp %h upd/err %b want 22 10", amplitude, {update, cmd_error}); end
  endtask

  task automatic test_invalid;
    strobe(8'h7F);
    n_cmp++; if ({cmd_error, update, busy} !== 3'b100) begin n_bad++; $display("FAIL invalid_op got err/upd/busy %b want 100", {cmd_error, update, busy}); end
    strobe(8'h30);
    strobe(8'h7F);
    finish_cmd(8'h4F);
    n_cmp++; if ({amplitude, cmd_error} !== {8'h7F, 1'b0}) begin n_bad++; $display("FAIL data_not_opcode got amp %h err %b want 7f 0", amplitude, cmd_error); end
  endtask

  task automatic test_back_to_back;
    strobe(8'h13);
    n_cmp++; if (wave_sel !== 2'd3) begin n_bad++; $display("FAIL b2b_wave got %0d want 3", wave_sel); end
    strobe(8'h20);
    strobe(8'hAA);
    strobe(8'h55);
    finish_cmd(8'hDF);
    n_cmp++; if ({freq_word, update} !== {16'hAA55, 1'b1}) begin n_bad++; $display("FAIL b2b_freq got %h upd %b want aa55 1", freq_word, update); end
    strobe(8'h40);
    n_cmp++; if ({out_en, update} !== 2'b01) begin n_bad++; $display("FAIL b2b_en got en/upd %b want 01", {out_en, update}); end
  endtask

  task automatic test_reset_mid;
    strobe(8'h20);
    strobe(8'h55);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    n_cmp++; if ({wave_sel, freq_word, amplitude, out_en, update, cmd_error, busy} !== {2'd0, 16'h0100, 8'hFF, 4'b0000})
      begin n_bad++; $display("FAIL reset_mid got %h %h %h %b want 0 0100 ff 0000", wave_sel, freq_word, amplitude, {out_en, update, cmd_error, busy}); end
    strobe(8'h11);
    n_cmp++; if ({wave_sel, busy} !== {2'd1, 1'b0}) begin n_bad++; $display("FAIL idle_after_rst got wave %0d busy %b want 1 0", wave_sel, busy); end
  endtask

`ifdef CMD_CHECKSUM_EN
  task automatic test_checksum;
    strobe(8'h31);
    strobe(8'h40);
    strobe(8'h71);
    n_cmp++; if ({amplitude, update} !== {8'h40, 1'b1}) begin n_bad++; $display("FAIL csum_ok got %h upd %b want 40 1", amplitude, update); end
    strobe(8'h31);
    strobe(8'h55);
    strobe(8'h70);
    n_cmp++; if ({amplitude, update, cmd_error} !== {8'h40, 2'b01}) begin n_bad++; $display("FAIL csum_bad got %h upd/err %b want 40 01", amplitude, {update, cmd_error}); end
  endtask
`endif

  initial begin
    rst            = 1'b1;
    command        = 8'h00;
    command_signal = 1'b0;
    test_reset();
    test_single();
    test_freq();
    test_timeout();
    test_invalid();
    test_back_to_back();
`ifdef CMD_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
Consumes the byte stream from the SPI client (command byte plus one-cycle command_signal strobe). Parses single- and multi-byte opcodes into the waveform generator's control registers: waveform select, frequency tuning word, amplitude, output enable. Sits between the SPI client and the wavegen core, in the same clock domain as both. Aborts incomplete commands on an inter-byte timeout and flags malformed input.

Parameters:
FREQ_BYTES, 2, number of data bytes in a SET_FREQ command; freq_word width = 8*FREQ_BYTES
FREQ_DEFAULT, 16'h0100, reset value of freq_word (width 8*FREQ_BYTES)
AMP_DEFAULT, 8'hFF, reset value of amplitude
TIMEOUT_CYCLES, 100000, max clk cycles allowed between bytes of one command

Ports:
clk  input  1  system clock, shared with the SPI client
rst  input  1  synchronous active-high reset
command  input  8  received byte from the SPI client
command_signal  input  1  one-cycle strobe, command valid
wave_sel  output  2  0 sine, 1 square, 2 triangle, 3 sawtooth
freq_word  output  8*FREQ_BYTES  phase-accumulator tuning word
amplitude  output  8  output scale
out_en  output  1  wavegen output enable
update  output  1  one-cycle pulse when any control register is written
cmd_error  output  1  one-cycle pulse on an invalid opcode, timeout, or checksum fail
busy  output  1  high while a multi-byte command is in progress

Behaviour:
- Reset (clk edge with rst=1): wave_sel=0, freq_word=FREQ_DEFAULT, amplitude=AMP_DEFAULT, out_en=0, update=0, cmd_error=0, busy=0, state=IDLE, timer=0, byte counter=0. Reset mid-command discards partial data with no update.
- Opcode byte, high nibble selects the command:
  - 0x1: SET_WAVE, single byte, wave_sel <= command[1:0].
  - 0x2: SET_FREQ, followed by FREQ_BYTES data bytes, MSB first.
  - 0x3: SET_AMP, followed by 1 data byte.
  - 0x4: SET_EN, single byte, out_en <= command[0].
  - Any other nibble: cmd_error pulse, stay IDLE, no register change.
- States:
  - IDLE: busy=0. Waits for command_signal. Single-byte ops apply immediately. Multi-byte ops latch the opcode, clear the byte counter and timer, and go to DATA.
  - DATA: busy=1. Each strobe shifts the byte into a staging register and increments the counter. When the last data byte arrives, the target register is loaded from staging and the block returns to IDLE (or goes to CHECK if the option is enabled).
  - CHECK: present only with the option enabled; see Optional Feature.
- Staging: freq_word is never partially updated. The register changes atomically only when the full word is received.
- Latency: register change and update pulse occur on the clk edge after the clk in which the final byte's command_signal is high (one-cycle registered). cmd_error has the same one-cycle latency.
- Timeout:
  - The timer counts clk cycles while in DATA or CHECK and resets to 0 on each strobe.
  - On reaching TIMEOUT_CYCLES-1 with no strobe: cmd_error pulse, return to IDLE, staged data discarded.
  - A strobe in the same cycle as the timer expiry wins: the byte is accepted and the timer is cleared.
- In DATA, bytes are data regardless of value; an opcode-looking byte is not reinterpreted.
- update and cmd_error are never high in the same cycle.
- Back-to-back strobes on consecutive cycles must be accepted without loss.

Optional Feature:
- Macro CMD_CHECKSUM_EN.
- Enabled: every multi-byte command is followed by one checksum byte equal to the XOR of the opcode and all data bytes; the state machine enters CHECK for this byte.
  - Match: registers load and update pulses, one cycle after the checksum strobe.
  - Mismatch: cmd_error pulses, no register change, return to IDLE.
  - Timeout also applies in CHECK.
  - Single-byte commands carry no checksum.
- Disabled: no CHECK state; registers load on the last data byte.

Test Plan:
- Reset released, no strobes -> wave_sel=0, freq_word=0x0100, amplitude=0xFF, out_en=0, busy=0, no update or cmd_error pulses.
- Strobe 0x12, then strobe 0x41 -> wave_sel=2 with an update pulse one cycle after the first strobe; out_en=1 with an update pulse one cycle after the second.
- Strobes 0x20, 0x12, 0x34 spaced 10 cycles apart -> busy high from after 0x20 until completion; freq_word=0x1234 exactly one cycle after 0x34; freq_word unchanged before then.
- Strobes 0x20, 0xAB, then silence for TIMEOUT_CYCLES -> cmd_error single pulse, busy=0, freq_word unchanged; next strobe 0x31, 0x80 -> amplitude=0x80.
- Strobe 0x7F in IDLE -> cmd_error pulse, no update, still IDLE; assert rst mid-SET_FREQ (after 0x20, 0x55) -> all outputs return to reset values.
- With CMD_CHECKSUM_EN: 0x31, 0x40, 0x71 -> amplitude=0x40 with update; 0x31, 0x40, 0x70 -> cmd_error, amplitude unchanged.
